// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, ALU operation
// encoding, the ID/EX control payload and small decode helper functions.
package riscv_pkg;

    localparam int unsigned ILEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ALU_OP_W = 4;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 4'd10;

    // Control payload carried in the ID/EX register
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic                illegal;
    } ctrl_t;

    // Opcode-class flag: execute uses PC instead of rs1 as operand A
    function automatic logic opc_uses_pc(input logic [6:0] opc);
        return (opc == OPC_AUIPC);
    endfunction

    // funct3 (+ instr[30]) to ALU operation; SUB only exists for register-register
    function automatic logic [ALU_OP_W-1:0] alu_op_from_f3(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_op
    );
        logic [ALU_OP_W-1:0] op;
        case (f3)
            3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate of the given
// format from an RV32I instruction word.
//   instr_i    : instruction word
//   imm_type_i : immediate format (I/S/B/U/J)
//   imm_o      : XLEN-wide sign-extended immediate (combinational)
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ILEN-1:0] instr_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type_i)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives register-file read addresses, applies write-back
// bypass, decodes control/immediate and registers the result into ID/EX with
// a valid/ready handshake, load-use bubble insertion and flush.
//   clk, reset              : clock, async active-high reset
//   if_valid/if_instr/if_pc : instruction from fetch; id_ready accepts it
//   read_reg1/2, read_data1/2 : register_file read port
//   wb_reg_write/wb_rd/wb_data : write-back for bypass
//   flush                   : kill ID and ID/EX contents
//   ex_ready, ex_*          : ID/EX register towards execute
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_valid,
    input  logic [ILEN-1:0]     if_instr,
    input  logic [XLEN-1:0]     if_pc,
    output logic                id_ready,
    output logic [REG_AW-1:0]   read_reg1,
    output logic [REG_AW-1:0]   read_reg2,
    input  logic [XLEN-1:0]     read_data1,
    input  logic [XLEN-1:0]     read_data2,
    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_rs1_data,
    output logic [XLEN-1:0]     ex_rs2_data,
    output logic [XLEN-1:0]     ex_imm,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic [2:0]          ex_funct3,
    output logic                ex_illegal
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [2:0]        funct3;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    assign read_reg1 = rs1;
    assign read_reg2 = rs2;

    // Write-back bypass, per operand; x0 never bypasses
    logic [XLEN-1:0] op_a, op_b;
    assign op_a = (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1)) ? wb_data : read_data1;
    assign op_b = (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2)) ? wb_data : read_data2;

    // Opcode decode
    ctrl_t     dec;
    imm_type_e imm_type;
    logic      uses_rs1, uses_rs2;

    always_comb begin
        dec      = '0;
        imm_type = IMM_I;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.alu_op = ALU_PASS_B; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                imm_type = IMM_U; uses_rs1 = 1'b0;
            end
            OPC_AUIPC: begin
                dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                imm_type = IMM_U; uses_rs1 = 1'b0;
            end
            OPC_JAL: begin
                dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.jump = 1'b1; imm_type = IMM_J; uses_rs1 = 1'b0;
            end
            OPC_JALR: begin
                dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.jump = 1'b1; imm_type = IMM_I;
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_SUB; dec.branch = 1'b1;
                imm_type = IMM_B; uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.mem_read = 1'b1; imm_type = IMM_I;
            end
            OPC_STORE: begin
                dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                imm_type = IMM_S; uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                dec.alu_op = alu_op_from_f3(funct3, if_instr[30], 1'b0);
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; imm_type = IMM_I;
            end
            OPC_OP: begin
                dec.alu_op = alu_op_from_f3(funct3, if_instr[30], 1'b1);
                dec.reg_write = 1'b1; uses_rs2 = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // Writes to x0 are architecturally discarded
        if (rd == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    logic [XLEN-1:0] imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i    (if_instr),
        .imm_type_i (imm_type),
        .imm_o      (imm)
    );

    // ID/EX register state
    logic              valid_q,  valid_d;
    ctrl_t             ctrl_q,   ctrl_d;
    logic [XLEN-1:0]   pc_q,     pc_d;
    logic [XLEN-1:0]   rs1_q,    rs1_d;
    logic [XLEN-1:0]   rs2_q,    rs2_d;
    logic [XLEN-1:0]   imm_q,    imm_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [2:0]        f3_q,     f3_d;

    // Load-use hazard against the load currently held in ID/EX
    logic hazard, advance;
    assign hazard  = if_valid && valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                     ((uses_rs1 && (rd_q == rs1)) || (uses_rs2 && (rd_q == rs2)));
    assign advance = !valid_q || ex_ready;
    assign id_ready = advance && (flush || !hazard);

    // Next ID/EX contents; control is cleared whenever the slot goes invalid
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        if (flush || (advance && hazard)) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (advance) begin
            valid_d = if_valid;
            ctrl_d  = if_valid ? dec : '0;
            pc_d    = if_pc;
            rs1_d   = op_a;
            rs2_d   = op_b;
            imm_d   = imm;
            rd_d    = rd;
            f3_d    = funct3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= RESET_PC;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_data  = rs1_q;
    assign ex_rs2_data  = rs2_q;
    assign ex_imm       = imm_q;
    assign ex_rd        = rd_q;
    assign ex_funct3    = f3_q;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_alu_src   = ctrl_q.alu_src;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_branch    = ctrl_q.branch;
    assign ex_jump      = ctrl_q.jump;
    assign ex_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, load-use bubble, bypass,
// backpressure, flush, illegal opcode, immediate formats and async reset.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  read_reg1, read_reg2;
    logic [31:0] read_data1, read_data2;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_jump, ex_illegal;
    logic [2:0]  ex_funct3;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_alu_op    (ex_alu_op),
        .ex_alu_src   (ex_alu_src),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .ex_funct3    (ex_funct3),
        .ex_illegal   (ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        read_data1 = '0; read_data2 = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, RST_PC);
        chk("rst_regwr", 32'(ex_reg_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // addi x1,x0,5
        drive(32'h0050_0093, 32'h0000_0010);
        chk("addi_rdaddr1", 32'(read_reg1), 32'd0);
        chk("addi_idready", 32'(id_ready), 32'd1);
        tick();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_rd", 32'(ex_rd), 32'd1);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_aluop", 32'(ex_alu_op), 32'd0);
        chk("addi_alusrc", 32'(ex_alu_src), 32'd1);
        chk("addi_regwr", 32'(ex_reg_write), 32'd1);
        chk("addi_pc", ex_pc, 32'h0000_0010);

        // lw x2,0(x1) then add x3,x2,x2: one bubble
        drive(32'h0000_A103, 32'h0000_0014);
        chk("lw_rdaddr1", 32'(read_reg1), 32'd1);
        tick();
        chk("lw_memrd", 32'(ex_mem_read), 32'd1);
        chk("lw_rd", 32'(ex_rd), 32'd2);
        chk("lw_f3", 32'(ex_funct3), 32'd2);
        drive(32'h0021_01B3, 32'h0000_0018);
        chk("haz_idready", 32'(id_ready), 32'd0);
        tick();
        chk("haz_bubble", 32'(ex_valid), 32'd0);
        chk("haz_bub_regwr", 32'(ex_reg_write), 32'd0);
        chk("haz_idready2", 32'(id_ready), 32'd1);
        tick();
        chk("haz_add_valid", 32'(ex_valid), 32'd1);
        chk("haz_add_rd", 32'(ex_rd), 32'd3);
        chk("haz_add_op", 32'(ex_alu_op), 32'd0);
        chk("haz_add_src", 32'(ex_alu_src), 32'd0);

        // Bypass: add x3,x2,x0 with write-back to x2
        read_data1 = 32'h0; read_data2 = 32'h55;
        wb_reg_write = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
        drive(32'h0001_01B3, 32'h0000_001C);
        tick();
        chk("byp_rs1", ex_rs1_data, 32'hDEAD_BEEF);
        chk("byp_rs2_nobyp", ex_rs2_data, 32'h55);
        // add x3,x0,x2: bypass on operand B only
        read_data2 = 32'h0;
        drive(32'h0020_01B3, 32'h0000_0020);
        tick();
        chk("byp_rs2", ex_rs2_data, 32'hDEAD_BEEF);
        // x0 never bypasses
        wb_rd = 5'd0;
        drive(32'h0000_01B3, 32'h0000_0024);
        tick();
        chk("byp_x0", ex_rs1_data, 32'h0);
        wb_reg_write = 1'b0;

        // Backpressure: hold add x3 while addi x5,x0,7 waits
        ex_ready = 1'b0;
        drive(32'h0070_0293, 32'h0000_0028);
        chk("bp_idready", 32'(id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 32'(ex_valid), 32'd1);
            chk("bp_rd", 32'(ex_rd), 32'd3);
            chk("bp_pc", ex_pc, 32'h0000_0024);
            chk("bp_idready_h", 32'(id_ready), 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_rel_idready", 32'(id_ready), 32'd1);
        tick();
        chk("bp_rel_rd", 32'(ex_rd), 32'd5);
        chk("bp_rel_imm", ex_imm, 32'd7);

        // Flush with a valid instruction presented
        flush = 1'b1;
        drive(32'h0070_0293, 32'h0000_002C);
        chk("fl_idready", 32'(id_ready), 32'd1);
        tick();
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_regwr", 32'(ex_reg_write), 32'd0);
        flush = 1'b0;

        // Illegal opcode
        drive(32'hFFFF_FFFF, 32'h0000_0030);
        tick();
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_regwr", 32'(ex_reg_write), 32'd0);
        chk("ill_memrd", 32'(ex_mem_read), 32'd0);

        // sw x2,-4(x1): S-imm, no register write
        drive(32'hFE20_AE23, 32'h0000_0034);
        tick();
        chk("sw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("sw_memwr", 32'(ex_mem_write), 32'd1);
        chk("sw_regwr", 32'(ex_reg_write), 32'd0);
        chk("sw_illegal", 32'(ex_illegal), 32'd0);

        // lui x1,0x12345
        drive(32'h1234_50B7, 32'h0000_0038);
        tick();
        chk("lui_imm", ex_imm, 32'h1234_5000);
        chk("lui_op", 32'(ex_alu_op), 32'd10);

        // beq x1,x2,-8
        drive(32'hFE20_8CE3, 32'h0000_003C);
        tick();
        chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
        chk("beq_branch", 32'(ex_branch), 32'd1);
        chk("beq_op", 32'(ex_alu_op), 32'd1);

        // srai x1,x1,3
        drive(32'h4030_D093, 32'h0000_0040);
        tick();
        chk("srai_op", 32'(ex_alu_op), 32'd7);
        chk("srai_imm", ex_imm, 32'h0000_0403);

        // jal x1,+16
        drive(32'h0100_00EF, 32'h0000_0044);
        tick();
        chk("jal_imm", ex_imm, 32'd16);
        chk("jal_jump", 32'(ex_jump), 32'd1);
        chk("jal_valid", 32'(ex_valid), 32'd1);

        // Async reset between edges
        if_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_pc", ex_pc, RST_PC);
        chk("arst_jump", 32'(ex_jump), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
